snax_hwpe_periph_regfile: RTL and testbench
===========================================

Name: snax_hwpe_periph_regfile

Overview:
- Responder (slave) end of the 32-bit HWPE peripheral control protocol.
- Terminates the periph requests emitted by the Snitch-to-HWPE control bridge and holds the accelerator job register file.
- Runs a job-control FSM (trigger, busy, done, event) and returns the read/write responses that the bridge queues back to Snitch.
- Sits inside each SNAX HWPE wrapper, between the control bridge and the datapath engine.

Parameters:
- NumRegs, 8, number of 32-bit generic job registers; 1..32.
- IdWidth, 5, width of the periph transaction id.
- RegOffset, 4, word index of job register 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- periph_req_i  in  1  request valid
- periph_gnt_o  out  1  request granted
- periph_add_i  in  32  byte address; word index = add[31:2]
- periph_wen_i  in  1  1 = read, 0 = write
- periph_be_i  in  4  write byte enables
- periph_data_i  in  32  write data
- periph_id_i  in  IdWidth  transaction id
- periph_r_data_o  out  32  response data
- periph_r_valid_o  out  1  response valid, single-cycle pulse, no backpressure
- periph_r_id_o  out  IdWidth  id echoed from the granted request
- job_regs_o  out  NumRegs*32  job register contents to the engine; reg i at bits [32i+31:32i]
- start_o  out  1  one-cycle job start pulse
- busy_o  out  1  job in flight
- done_i  in  1  engine completion pulse
- evt_o  out  1  one-cycle completion event

Behaviour:
- Reset (rst_i=1, asynchronous): all outputs 0. FSM goes to IDLE. Job regs, done flag and job counter go to 0.
- Grant: periph_gnt_o = periph_req_i, combinational. The responder never stalls.
- Response: exactly one response per granted request, registered, 1 cycle after grant.
  - r_valid=1 for that cycle; r_id = request id.
  - Read: r_data = register value sampled in the grant cycle, before any same-cycle update.
  - Write: r_data = 0.
  - Back-to-back requests produce back-to-back responses.
- Register map (word index):
  - 0 TRIGGER: write in IDLE starts a job. Write in any other state is ignored. Reads 0.
  - 1 STATUS: bit0 busy, bit1 done (sticky). A read returns the value and clears done in the same cycle. Writes ignored.
  - 2 SOFT_CLEAR: any write forces IDLE and clears job regs, done and counter. start_o is suppressed that cycle. Reads 0.
  - 3 JOB_COUNT: 32-bit count of completed jobs; wraps 0xFFFFFFFF -> 0. Read-only.
  - RegOffset .. RegOffset+NumRegs-1: job registers, byte-masked by be. Writes are ignored while busy_o=1 (no corruption of the running job). Reads always allowed.
  - Any other index: read returns 0, write ignored. A response is still generated.
- FSM states IDLE, START, BUSY, DONE:
  - IDLE -> START on an accepted TRIGGER write. start_o=1 during START (exactly 1 cycle).
  - START -> BUSY.
  - BUSY -> DONE when done_i=1.
  - DONE: evt_o=1, done flag set, counter +1; -> IDLE next cycle.
  - busy_o = 1 in START, BUSY and DONE.
  - done_i outside BUSY is ignored.
  - A trigger write in DONE is ignored; software polls STATUS.
- Simultaneous events:
  - STATUS read in the DONE cycle returns done=0 (pre-update value) and does not clear the flag being set that cycle.
  - SOFT_CLEAR has priority over done_i and TRIGGER.
- Reset mid-job: immediate return to IDLE. No evt_o, no pending response is emitted.

Decomposition:
- Shared package snax_hwpe_periph_pkg holds:
  - register index constants (TRIGGER, STATUS, SOFT_CLEAR, JOB_COUNT);
  - FSM state enum;
  - packed response struct {r_id, r_valid, r_data} shared with the bridge's response typedef.
- One natural sub-module: snax_hwpe_job_fsm (FSM, counter, done flag, start/evt). Register decode and the response register stay in the top.

Test Plan:
- Reset: assert rst_i mid-cycle -> all outputs 0 immediately; STATUS read after release returns 0x0.
- Write/readback: write 0xA5A5_1234 be=4'hF to index 4 (addr 0x10), then write 0x0000_FF00 be=4'b0010 -> read returns 0xA5A5_FF34 with r_id echoed, r_valid exactly 1 cycle after each grant.
- Job flow: write TRIGGER -> start_o pulse 1 cycle later, busy_o=1; drive done_i after 10 cycles -> evt_o pulse; STATUS read = 0x2 and next STATUS read = 0x0; JOB_COUNT = 1.
- Busy protection: during BUSY write 0xFFFFFFFF to index 4 and write TRIGGER -> job reg unchanged, no second start_o, both writes still get responses.
- Soft clear: SOFT_CLEAR in the same cycle as done_i -> FSM IDLE, no evt_o, JOB_COUNT = 0, job regs 0.
- Throughput/unmapped: 8 back-to-back reads incl. index 31 with NumRegs=8 -> 8 consecutive r_valid cycles, ids in order, unmapped returns 0.

Source files
------------

// File: rtl/snax_hwpe_periph_pkg.sv
// Shared definitions for the SNAX HWPE peripheral responder: control register
// indices, job FSM states and the response record also used by the control bridge.
package snax_hwpe_periph_pkg;

   localparam int unsigned REG_TRIGGER    = 0;
   localparam int unsigned REG_STATUS     = 1;
   localparam int unsigned REG_SOFT_CLEAR = 2;
   localparam int unsigned REG_JOB_COUNT  = 3;

   // Widest id the response record can carry; instances narrow it to IdWidth.
   localparam int unsigned MAX_ID_WIDTH = 16;

   typedef enum logic [1:0] {
      JOB_IDLE  = 2'd0,
      JOB_START = 2'd1,
      JOB_BUSY  = 2'd2,
      JOB_DONE  = 2'd3
   } job_state_e;

   typedef struct packed {
      logic [MAX_ID_WIDTH-1:0] r_id;
      logic                    r_valid;
      logic [31:0]             r_data;
   } periph_rsp_t;

endpackage

// File: rtl/snax_hwpe_job_fsm.sv
// Job-control FSM: trigger/start/busy/done sequencing, sticky done flag and
// completed-job counter. Soft clear overrides every other event.
module snax_hwpe_job_fsm
   import snax_hwpe_periph_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        trigger_i,
   input  logic        soft_clear_i,
   input  logic        status_rd_i,
   input  logic        done_i,
   output job_state_e  state_o,
   output logic        start_o,
   output logic        evt_o,
   output logic        done_flag_o,
   output logic [31:0] job_count_o
);

   job_state_e  state_q, state_d;
   logic        done_flag_q, done_flag_d;
   logic [31:0] count_q, count_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= JOB_IDLE;
         done_flag_q <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         done_flag_q <= done_flag_d;
         count_q     <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      done_flag_d = done_flag_q;
      count_d     = count_q;
      start_o     = 1'b0;
      evt_o       = 1'b0;
      case (state_q)
         JOB_IDLE:  if (trigger_i) state_d = JOB_START;
         JOB_START: begin
            start_o = 1'b1;
            state_d = JOB_BUSY;
         end
         JOB_BUSY:  if (done_i) state_d = JOB_DONE;
         JOB_DONE:  begin
            evt_o   = 1'b1;
            state_d = JOB_IDLE;
         end
         default:   state_d = JOB_IDLE;
      endcase
      // A STATUS read in the DONE cycle sees the old flag, so setting wins over clearing.
      if (status_rd_i) done_flag_d = 1'b0;
      if (state_q == JOB_DONE) begin
         done_flag_d = 1'b1;
         count_d     = count_q + 32'd1;
      end
      if (soft_clear_i) begin
         state_d     = JOB_IDLE;
         done_flag_d = 1'b0;
         count_d     = '0;
         start_o     = 1'b0;
         evt_o       = 1'b0;
      end
   end

   assign state_o     = state_q;
   assign done_flag_o = done_flag_q;
   assign job_count_o = count_q;

endmodule

// File: rtl/snax_hwpe_periph_regfile.sv
// Responder end of the HWPE periph control port: register decode, job register
// file and the registered response path, wrapped around the job FSM.
module snax_hwpe_periph_regfile
   import snax_hwpe_periph_pkg::*;
#(
   parameter int NumRegs   = 8,
   parameter int IdWidth   = 5,
   parameter int RegOffset = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  periph_req_i,
   output logic                  periph_gnt_o,
   input  logic [31:0]           periph_add_i,
   input  logic                  periph_wen_i,
   input  logic [3:0]            periph_be_i,
   input  logic [31:0]           periph_data_i,
   input  logic [IdWidth-1:0]    periph_id_i,
   output logic [31:0]           periph_r_data_o,
   output logic                  periph_r_valid_o,
   output logic [IdWidth-1:0]    periph_r_id_o,
   output logic [NumRegs*32-1:0] job_regs_o,
   output logic                  start_o,
   output logic                  busy_o,
   input  logic                  done_i,
   output logic                  evt_o
);

   // Handshake: every cycle with req high is a granted transfer (gnt mirrors req);
   // exactly one r_valid pulse carrying its id follows one cycle later, and the
   // response side has no ready, so the requester must always accept it.
   assign periph_gnt_o = periph_req_i;

   logic [29:0] word_idx, job_rel;
   logic        wr_req, rd_req, job_hit;
   logic        trigger_wr, soft_clear_wr, status_rd;
   job_state_e  job_state;
   logic        done_flag;
   logic [31:0] job_count, rd_data;
   logic [31:0] job_q [NumRegs];
   periph_rsp_t rsp_q;
   logic        unused_bits;

   assign word_idx      = periph_add_i[31:2];
   assign wr_req        = periph_req_i & ~periph_wen_i;
   assign rd_req        = periph_req_i & periph_wen_i;
   assign trigger_wr    = wr_req && (word_idx == 30'(REG_TRIGGER));
   assign soft_clear_wr = wr_req && (word_idx == 30'(REG_SOFT_CLEAR));
   assign status_rd     = rd_req && (word_idx == 30'(REG_STATUS));
   assign job_rel       = word_idx - 30'(RegOffset);
   assign job_hit       = (word_idx >= 30'(RegOffset)) && (job_rel < 30'(NumRegs));

   snax_hwpe_job_fsm i_job_fsm (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .trigger_i    (trigger_wr),
      .soft_clear_i (soft_clear_wr),
      .status_rd_i  (status_rd),
      .done_i       (done_i),
      .state_o      (job_state),
      .start_o      (start_o),
      .evt_o        (evt_o),
      .done_flag_o  (done_flag),
      .job_count_o  (job_count)
   );

   assign busy_o = (job_state != JOB_IDLE);

   // Job registers are frozen while a job runs so the engine sees stable arguments.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumRegs; i++) job_q[i] <= '0;
      end else if (soft_clear_wr) begin
         for (int i = 0; i < NumRegs; i++) job_q[i] <= '0;
      end else if (wr_req && job_hit && !busy_o) begin
         for (int i = 0; i < NumRegs; i++) begin
            if (job_rel == 30'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (periph_be_i[b]) job_q[i][8*b +: 8] <= periph_data_i[8*b +: 8];
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NumRegs; g++) begin : g_job_out
      assign job_regs_o[32*g +: 32] = job_q[g];
   end

   always_comb begin
      rd_data = '0;
      if (job_hit) begin
         for (int i = 0; i < NumRegs; i++) begin
            if (job_rel == 30'(i)) rd_data = job_q[i];
         end
      end else if (word_idx == 30'(REG_STATUS)) begin
         rd_data = {30'd0, done_flag, busy_o};
      end else if (word_idx == 30'(REG_JOB_COUNT)) begin
         rd_data = job_count;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_q <= '0;
      end else begin
         rsp_q.r_valid <= periph_req_i;
         rsp_q.r_id    <= MAX_ID_WIDTH'(periph_id_i);
         rsp_q.r_data  <= rd_req ? rd_data : 32'd0;
      end
   end

   assign periph_r_valid_o = rsp_q.r_valid;
   assign periph_r_data_o  = rsp_q.r_data;
   assign periph_r_id_o    = rsp_q.r_id[IdWidth-1:0];
   assign unused_bits      = ^{periph_add_i[1:0], rsp_q.r_id};

endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// Directed bench for snax_hwpe_periph_regfile: table of register transfers plus
// hand-written job flow, busy protection, soft clear and mid-job reset sequences.
module tb_snax_hwpe_periph_regfile;

   localparam int NumRegs = 8;
   localparam int IdWidth = 5;

   logic                  clk, rst;
   logic                  periph_req, periph_gnt, periph_wen;
   logic [31:0]           periph_add, periph_data, periph_r_data;
   logic [3:0]            periph_be;
   logic [IdWidth-1:0]    periph_id, periph_r_id;
   logic                  periph_r_valid;
   logic [NumRegs*32-1:0] job_regs;
   logic                  start, busy, done, evt;

   int tests = 0;
   int fails = 0;
   int start_cnt = 0;
   int evt_cnt = 0;
   int s0, e0;

   typedef struct {
      logic         wen;
      logic [29:0]  idx;
      logic [3:0]   be;
      logic [31:0]  data;
      logic [4:0]   id;
      logic [31:0]  exp;
   } vec_t;

   vec_t vecs[16];

   snax_hwpe_periph_regfile #(.NumRegs(NumRegs), .IdWidth(IdWidth), .RegOffset(4)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .periph_req_i     (periph_req),
      .periph_gnt_o     (periph_gnt),
      .periph_add_i     (periph_add),
      .periph_wen_i     (periph_wen),
      .periph_be_i      (periph_be),
      .periph_data_i    (periph_data),
      .periph_id_i      (periph_id),
      .periph_r_data_o  (periph_r_data),
      .periph_r_valid_o (periph_r_valid),
      .periph_r_id_o    (periph_r_id),
      .job_regs_o       (job_regs),
      .start_o          (start),
      .busy_o           (busy),
      .done_i           (done),
      .evt_o            (evt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (start) start_cnt++;
      if (evt) evt_cnt++;
   end

   // scoreboard helpers
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver: one granted transfer, returns in its response cycle
   task automatic xact(input logic wen, input logic [29:0] idx, input logic [3:0] be,
                       input logic [31:0] data, input logic [4:0] id,
                       input logic [31:0] exp, input string nm);
      periph_req  = 1'b1;
      periph_wen  = wen;
      periph_add  = {idx, 2'b00};
      periph_be   = be;
      periph_data = data;
      periph_id   = id;
      #1;
      check1({nm, " gnt"}, periph_gnt, 1'b1);
      @(posedge clk);
      #1;
      periph_req = 1'b0;
      check1({nm, " r_valid"}, periph_r_valid, 1'b1);
      check({nm, " r_id"}, {27'd0, periph_r_id}, {27'd0, id});
      check({nm, " r_data"}, periph_r_data, exp);
   endtask

   initial begin
      rst = 1'b1;
      periph_req = 1'b0; periph_wen = 1'b1; periph_add = '0; periph_be = '0;
      periph_data = '0; periph_id = '0; done = 1'b0;

      vecs[0]  = '{1'b0, 30'd4,  4'hF,    32'hA5A5_1234, 5'd1,  32'h0};
      vecs[1]  = '{1'b0, 30'd4,  4'b0010, 32'h0000_FF00, 5'd2,  32'h0};
      vecs[2]  = '{1'b1, 30'd4,  4'h0,    32'h0,         5'd3,  32'hA5A5_FF34};
      vecs[3]  = '{1'b0, 30'd5,  4'hF,    32'h1234_5678, 5'd4,  32'h0};
      vecs[4]  = '{1'b0, 30'd11, 4'b1001, 32'hDEAD_BEEF, 5'd5,  32'h0};
      vecs[5]  = '{1'b0, 30'd12, 4'hF,    32'hFFFF_FFFF, 5'd6,  32'h0};
      vecs[6]  = '{1'b0, 30'd1,  4'hF,    32'hFFFF_FFFF, 5'd7,  32'h0};
      vecs[7]  = '{1'b0, 30'd3,  4'hF,    32'hFFFF_FFFF, 5'd8,  32'h0};
      vecs[8]  = '{1'b1, 30'd5,  4'h0,    32'h0,         5'd9,  32'h1234_5678};
      vecs[9]  = '{1'b1, 30'd11, 4'h0,    32'h0,         5'd10, 32'hDE00_00EF};
      vecs[10] = '{1'b1, 30'd12, 4'h0,    32'h0,         5'd11, 32'h0};
      vecs[11] = '{1'b1, 30'd31, 4'h0,    32'h0,         5'd12, 32'h0};
      vecs[12] = '{1'b1, 30'd1,  4'h0,    32'h0,         5'd13, 32'h0};
      vecs[13] = '{1'b1, 30'd3,  4'h0,    32'h0,         5'd14, 32'h0};
      vecs[14] = '{1'b1, 30'd0,  4'h0,    32'h0,         5'd15, 32'h0};
      vecs[15] = '{1'b1, 30'd4,  4'h0,    32'h0,         5'd16, 32'hA5A5_FF34};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check1("rst gnt", periph_gnt, 1'b0);
      check1("rst r_valid", periph_r_valid, 1'b0);
      check("rst r_data", periph_r_data, 32'h0);
      check1("rst start", start, 1'b0);
      check1("rst busy", busy, 1'b0);
      check1("rst evt", evt, 1'b0);
      check1("rst job_regs zero", job_regs == '0, 1'b1);
      rst = 1'b0;
      tick();
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd0, 32'h0, "status after reset");
      tick();

      // table: write/readback, ignored writes, back-to-back reads incl. unmapped
      for (int i = 0; i < 16; i++) begin
         xact(vecs[i].wen, vecs[i].idx, vecs[i].be, vecs[i].data, vecs[i].id, vecs[i].exp,
              $sformatf("vec%0d", i));
      end
      tick();
      check1("r_valid single pulse", periph_r_valid, 1'b0);
      check("job_regs reg0", job_regs[31:0], 32'hA5A5_FF34);
      check("job_regs reg7", job_regs[32*7 +: 32], 32'hDE00_00EF);

      // job flow
      s0 = start_cnt; e0 = evt_cnt;
      xact(1'b0, 30'd0, 4'hF, 32'h1, 5'd17, 32'h0, "trigger");
      check1("start pulse", start, 1'b1);
      check1("busy in start", busy, 1'b1);
      tick();
      check1("start cleared", start, 1'b0);
      check1("busy in busy", busy, 1'b1);
      repeat (9) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check1("evt pulse", evt, 1'b1);
      check1("busy in done", busy, 1'b1);
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd18, 32'h1, "status in done cycle");
      check1("evt cleared", evt, 1'b0);
      check1("idle after done", busy, 1'b0);
      tick();
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd19, 32'h2, "status done");
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd20, 32'h0, "status cleared");
      xact(1'b1, 30'd3, 4'h0, 32'h0, 5'd21, 32'h1, "job count 1");
      tick();
      check("job1 start count", start_cnt - s0, 32'd1);
      check("job1 evt count", evt_cnt - e0, 32'd1);

      // done_i outside BUSY is ignored
      done = 1'b1;
      tick(); tick();
      done = 1'b0;
      check1("done in idle busy", busy, 1'b0);
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd1, 32'h0, "status stray done");
      xact(1'b1, 30'd3, 4'h0, 32'h0, 5'd2, 32'h1, "count stray done");
      tick();

      // busy protection
      s0 = start_cnt;
      xact(1'b0, 30'd0, 4'hF, 32'h1, 5'd22, 32'h0, "trigger2");
      tick();
      xact(1'b0, 30'd4, 4'hF, 32'hFFFF_FFFF, 5'd23, 32'h0, "busy job wr");
      xact(1'b0, 30'd0, 4'hF, 32'h1, 5'd24, 32'h0, "busy trigger");
      xact(1'b1, 30'd4, 4'h0, 32'h0, 5'd25, 32'hA5A5_FF34, "busy job rd");
      check("busy job_regs reg0", job_regs[31:0], 32'hA5A5_FF34);
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd3, 32'h1, "status busy");
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      check("job2 start count", start_cnt - s0, 32'd1);
      xact(1'b1, 30'd3, 4'h0, 32'h0, 5'd4, 32'h2, "job count 2");
      tick();

      // soft clear together with done_i
      e0 = evt_cnt;
      xact(1'b0, 30'd0, 4'hF, 32'h1, 5'd26, 32'h0, "trigger3");
      tick();
      done = 1'b1;
      xact(1'b0, 30'd2, 4'hF, 32'h1, 5'd27, 32'h0, "soft clear");
      done = 1'b0;
      check1("busy after clear", busy, 1'b0);
      tick(); tick();
      check("clear evt count", evt_cnt - e0, 32'd0);
      check1("clear job_regs zero", job_regs == '0, 1'b1);
      xact(1'b1, 30'd3, 4'h0, 32'h0, 5'd28, 32'h0, "count after clear");
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd29, 32'h0, "status after clear");
      xact(1'b1, 30'd4, 4'h0, 32'h0, 5'd30, 32'h0, "job reg after clear");
      tick();

      // asynchronous reset in the middle of a job with a live response
      e0 = evt_cnt;
      xact(1'b0, 30'd4, 4'hF, 32'h0BAD_F00D, 5'd31, 32'h0, "pre-reset job wr");
      xact(1'b0, 30'd0, 4'hF, 32'h1, 5'd5, 32'h0, "trigger4");
      tick();
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd6, 32'h1, "status before reset");
      #3;
      rst = 1'b1;
      #1;
      check1("midrst r_valid", periph_r_valid, 1'b0);
      check("midrst r_id", {27'd0, periph_r_id}, 32'h0);
      check("midrst r_data", periph_r_data, 32'h0);
      check1("midrst busy", busy, 1'b0);
      check1("midrst start", start, 1'b0);
      check1("midrst evt", evt, 1'b0);
      check1("midrst job_regs zero", job_regs == '0, 1'b1);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check1("post-reset r_valid", periph_r_valid, 1'b0);
      check1("post-reset busy", busy, 1'b0);
      check("post-reset evt count", evt_cnt - e0, 32'd0);
      xact(1'b1, 30'd1, 4'h0, 32'h0, 5'd7, 32'h0, "status after midrst");
      xact(1'b1, 30'd3, 4'h0, 32'h0, 5'd8, 32'h0, "count after midrst");
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
